// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch stage in front of a multi-cycle instruction ROM. Owns the
// program counter, issues one ROM read at a time, holds the request steady
// while the ROM stalls, and parks the returned word in a one-entry IF/ID
// register handed to decode through a valid/ready handshake. A redirect
// reloads the PC and drops whatever fetch or held instruction is in flight.
//
// Parameters
//   RESET_PC      byte PC loaded on reset (bits [1:0] ignored)
//   TIMEOUT       FETCH cycles allowed before the fetch is abandoned and retried
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           asynchronous reset, active low
//   redirect      load redirect_pc and kill in-flight/held instruction
//   redirect_pc   new byte PC (bits [1:0] forced to 0)
//   id_ready      decode accepts if_inst this cycle
//   mem_cs        ROM chip-select
//   mem_addr      ROM word address, {2'b00, pc[31:2]}
//   mem_dout      ROM read data
//   mem_stall     ROM busy; read completes when mem_cs & ~mem_stall
//   if_valid      if_pc/if_inst hold a valid instruction
//   if_pc         byte PC of if_inst
//   if_inst       fetched instruction
//   fetch_timeout one-cycle pulse when a fetch is abandoned by timeout
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        mem_cs,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        mem_stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [31:0] PC_INIT  = RESET_PC & ~32'd3;
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        valid_nx;
    logic [31:0] if_pc_nx;
    logic [31:0] if_inst_nx;
    logic        timeout_nx;

    // Chip-select is decoded straight from the state so that an asynchronous
    // reset drops it immediately, abandoning any fetch in progress.
    assign mem_cs   = (state == FETCH);
    assign mem_addr = {2'b00, pc[31:2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc            <= PC_INIT;
            cnt           <= 8'd0;
            if_valid      <= 1'b0;
            if_pc         <= 32'd0;
            if_inst       <= 32'd0;
            fetch_timeout <= 1'b0;
        end else begin
            state         <= state_nx;
            pc            <= pc_nx;
            cnt           <= cnt_nx;
            if_valid      <= valid_nx;
            if_pc         <= if_pc_nx;
            if_inst       <= if_inst_nx;
            fetch_timeout <= timeout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        cnt_nx     = cnt;
        valid_nx   = if_valid;
        if_pc_nx   = if_pc;
        if_inst_nx = if_inst;
        timeout_nx = 1'b0;

        case (state)
            // One cycle with chip-select low so the ROM restarts its delay.
            IDLE: begin
                cnt_nx   = 8'd0;
                state_nx = FETCH;
            end

            FETCH: begin
                if (!mem_stall) begin
                    if_inst_nx = mem_dout;
                    if_pc_nx   = pc;
                    valid_nx   = 1'b1;
                    pc_nx      = pc + 32'd4;
                    state_nx   = WAIT;
                end else if (cnt == CNT_LAST) begin
                    // Give up on this attempt; pc is kept so the same word
                    // is requested again after the IDLE cycle.
                    timeout_nx = 1'b1;
                    cnt_nx     = 8'd0;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end

            WAIT: begin
                if (if_valid && id_ready) begin
                    valid_nx = 1'b0;
                    cnt_nx   = 8'd0;
                    state_nx = FETCH;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // Redirect overrides any completion or consumption in the same cycle.
        if (redirect) begin
            pc_nx      = redirect_pc & ~32'd3;
            valid_nx   = 1'b0;
            cnt_nx     = 8'd0;
            timeout_nx = 1'b0;
            state_nx   = IDLE;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed and randomized bench for inst_fetch. A behavioural ROM with a
// configurable delay answers the fetch stage; an expected-PC scoreboard
// predicts every delivered (pc, instruction) pair and the per-cycle protocol
// behaviour from the rules of the fetch stage.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic        mem_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_timeout;

    inst_fetch #(
        .RESET_PC (RPC),
        .TIMEOUT  (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .mem_cs        (mem_cs),
        .mem_addr      (mem_addr),
        .mem_dout      (mem_dout),
        .mem_stall     (mem_stall),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .fetch_timeout (fetch_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: stalls for rom_delay cycles of chip-select, then
    // returns the addressed word; rom_hang keeps it stalled forever.
    logic [31:0] rom [64];
    int          rom_delay;
    logic        rom_hang;
    int          rom_cnt = 0;

    always_ff @(posedge clk) rom_cnt <= mem_cs ? rom_cnt + 1 : 0;

    assign mem_stall = rom_hang || (rom_cnt < rom_delay);
    assign mem_dout  = mem_cs ? rom[mem_addr[5:0]] : 32'hDEAD_BEEF;

    // Scoreboard state
    logic [31:0] exp_pc;
    int          cs_run;
    int          n_deliv;
    int          n_pass;
    int          n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_reset_values();
        chk("rst_mem_cs",   {31'd0, mem_cs},        32'd0);
        chk("rst_mem_addr", mem_addr,               RPC >> 2);
        chk("rst_if_valid", {31'd0, if_valid},      32'd0);
        chk("rst_if_pc",    if_pc,                  32'd0);
        chk("rst_if_inst",  if_inst,                32'd0);
        chk("rst_timeout",  {31'd0, fetch_timeout}, 32'd0);
    endtask

    // Advance one clock and check what the stage did against its rules.
    task automatic cyc();
        logic        pre_cs, pre_stall, pre_valid, pre_ready, pre_redir;
        logic [31:0] pre_addr, pre_rpc, pre_ifpc, pre_ifinst;
        int          pre_run;
        pre_cs     = mem_cs;
        pre_stall  = mem_stall;
        pre_valid  = if_valid;
        pre_ready  = id_ready;
        pre_redir  = redirect;
        pre_addr   = mem_addr;
        pre_rpc    = redirect_pc;
        pre_ifpc   = if_pc;
        pre_ifinst = if_inst;
        pre_run    = cs_run;

        if (!pre_redir && pre_valid && pre_ready) begin
            chk("deliver_pc",   if_pc,   exp_pc);
            chk("deliver_inst", if_inst, rom[exp_pc[7:2]]);
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        if (pre_redir) exp_pc = pre_rpc & ~32'd3;

        @(posedge clk);
        #1;
        redirect = 1'b0;
        cs_run   = mem_cs ? cs_run + 1 : 0;

        if (!pre_cs && mem_cs) chk("fetch_addr", mem_addr, exp_pc >> 2);

        if (pre_redir) begin
            chk("redir_valid", {31'd0, if_valid}, 32'd0);
            chk("redir_cs",    {31'd0, mem_cs},   32'd0);
            chk("redir_addr",  mem_addr,          exp_pc >> 2);
        end else if (pre_cs && !pre_stall) begin
            chk("cmpl_valid", {31'd0, if_valid}, 32'd1);
            chk("cmpl_cs",    {31'd0, mem_cs},   32'd0);
            chk("cmpl_pc",    if_pc,             exp_pc);
            chk("cmpl_inst",  if_inst,           rom[exp_pc[7:2]]);
        end else if (pre_cs) begin
            if (pre_run == int'(TO)) begin
                chk("timeout_pulse", {31'd0, fetch_timeout}, 32'd1);
                chk("timeout_cs",    {31'd0, mem_cs},        32'd0);
            end else begin
                chk("stall_notimeout", {31'd0, fetch_timeout}, 32'd0);
                chk("stall_cs",        {31'd0, mem_cs},        32'd1);
                chk("stall_addr",      mem_addr,               pre_addr);
            end
        end else if (pre_valid && !pre_ready) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc",    if_pc,             pre_ifpc);
            chk("hold_inst",  if_inst,           pre_ifinst);
            chk("hold_cs",    {31'd0, mem_cs},   32'd0);
        end else if (pre_valid && pre_ready) begin
            chk("consume_cs",    {31'd0, mem_cs},   32'd1);
            chk("consume_valid", {31'd0, if_valid}, 32'd0);
        end else begin
            chk("idle_to_fetch", {31'd0, mem_cs}, 32'd1);
        end
    endtask

    task automatic run_until_deliv(input int target, input int budget);
        int i;
        i = 0;
        while (n_deliv < target && i < budget) begin
            cyc();
            i++;
        end
        chk("deliv_budget", {31'd0, n_deliv >= target}, 32'd1);
    endtask

    initial begin
        int i;
        n_pass      = 0;
        n_total     = 0;
        n_deliv     = 0;
        cs_run      = 0;
        exp_pc      = RPC & ~32'd3;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        id_ready    = 1'b0;
        rom_delay   = 8;
        rom_hang    = 1'b0;
        for (int k = 0; k < 64; k++) rom[k] = $urandom;
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;

        // Reset values, then release between edges
        #12;
        chk_reset_values();
        rst = 1'b1;
        #1;
        chk("release_cs", {31'd0, mem_cs}, 32'd0);

        // Straight-line fetch of three words
        id_ready = 1'b1;
        cyc();
        chk("first_cs", {31'd0, mem_cs}, 32'd1);
        run_until_deliv(3, 60);

        // Backpressure on the first word
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        cyc();
        i = 0;
        while (!if_valid && i < 40) begin cyc(); i++; end
        chk("bp_valid", {31'd0, if_valid}, 32'd1);
        chk("bp_pc",    if_pc,             32'h0);
        chk("bp_inst",  if_inst,           32'h11);
        for (int k = 0; k < 20; k++) cyc();
        chk("bp_held_inst", if_inst, 32'h11);
        id_ready = 1'b1;
        cyc();
        chk("bp_release_addr", mem_addr, 32'd1);

        // Redirect three cycles into the fetch of pc 4
        cyc();
        cyc();
        chk("mid_run", cs_run, 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0014;
        cyc();
        cyc();
        chk("mid_new_addr", mem_addr, 32'd5);
        run_until_deliv(n_deliv + 1, 40);

        // Redirect in the completion cycle
        i = 0;
        while (!(mem_cs && !mem_stall) && i < 40) begin cyc(); i++; end
        chk("coinc_reached", {31'd0, mem_cs && !mem_stall}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0020;
        cyc();
        run_until_deliv(n_deliv + 1, 40);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        cyc();
        run_until_deliv(n_deliv + 2, 60);

        // Timeout and retry of the same word
        rom_hang = 1'b1;
        i = 0;
        while (!fetch_timeout && i < 100) begin cyc(); i++; end
        chk("timeout_seen", {31'd0, fetch_timeout}, 32'd1);
        cyc();
        rom_hang = 1'b0;
        run_until_deliv(n_deliv + 1, 40);

        // Asynchronous reset in the middle of a fetch
        i = 0;
        while (!(mem_cs && cs_run == 3) && i < 40) begin cyc(); i++; end
        chk("arst_reached", {31'd0, mem_cs && cs_run == 3}, 32'd1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_values();
        rst    = 1'b1;
        exp_pc = RPC & ~32'd3;
        cs_run = 0;
        cyc();
        run_until_deliv(n_deliv + 1, 40);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            if (!mem_cs) rom_delay = $urandom_range(0, 6);
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
